// File: rtl/ins_cache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
`ifndef RAM_ADR_W
`define RAM_ADR_W 32
`endif
`ifndef DAT_W
`define DAT_W 32
`endif

interface ins_cache_if;
  logic                  if_en_i;
  logic [`RAM_ADR_W-1:0] if_pc_i;
  logic                  if_en_o;
  logic [`DAT_W-1:0]     if_ins_o;
  logic                  mc_en_o;
  logic [`RAM_ADR_W-1:0] mc_adr_o;
  logic                  mc_en_i;
  logic [`DAT_W-1:0]     mc_dat_i;
  logic                  br_flag_i;

  modport slave (
    input  if_en_i, if_pc_i, mc_en_i, mc_dat_i, br_flag_i,
    output if_en_o, if_ins_o, mc_en_o, mc_adr_o
  );
  modport master (
    output if_en_i, if_pc_i, mc_en_i, mc_dat_i, br_flag_i,
    input  if_en_o, if_ins_o, mc_en_o, mc_adr_o
  );
endinterface

// File: rtl/ins_cache.sv
// Direct-mapped read-only instruction cache; serves 32-bit windows at any
// halfword PC and refills whole lines one word at a time.
`ifndef RAM_ADR_W
`define RAM_ADR_W 32
`endif
`ifndef DAT_W
`define DAT_W 32
`endif

module ins_cache #(
  parameter int IDX_W = 4,
  parameter int OFF_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  ins_cache_if.slave  bus
);
  localparam int AW    = `RAM_ADR_W;
  localparam int DW    = `DAT_W;
  localparam int TAG_W = AW - IDX_W - OFF_W;
  localparam int WC_W  = OFF_W - 2;
  localparam int LINES = 1 << IDX_W;
  localparam int WPL   = 1 << WC_W;
  localparam int HW    = AW - 1;

  // PC in halfword units, split into its cache fields
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [WC_W-1:0]  wrd;
    logic             half;
  } hpc_t;

  typedef enum logic [1:0] {IDLE, CHECK, REFILL} state_t;

  state_t           st;
  logic [LINES-1:0] vld;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [DW-1:0]    dat_mem [LINES][WPL];
  logic [HW-1:0]    req_hpc;
  hpc_t             lo, hi;
  logic             lo_hit, hi_hit;
  logic [DW-1:0]    lo_word, hi_word;
  logic [DW/2-1:0]  lo_half, hi_half;
  logic [TAG_W-1:0] miss_tag, ref_tag;
  logic [IDX_W-1:0] miss_idx, ref_idx;
  logic [WC_W-1:0]  cnt;
  logic             killed;
  logic             unused_pc0;

  assign unused_pc0 = bus.if_pc_i[0];

  // the hi halfword wraps modulo the address space
  assign lo = hpc_t'(req_hpc);
  assign hi = hpc_t'(req_hpc + HW'(1));

  assign lo_hit  = vld[lo.idx] && (tag_mem[lo.idx] == lo.tag);
  assign hi_hit  = vld[hi.idx] && (tag_mem[hi.idx] == hi.tag);
  assign lo_word = dat_mem[lo.idx][lo.wrd];
  assign hi_word = dat_mem[hi.idx][hi.wrd];
  assign lo_half = lo.half ? lo_word[DW-1:DW/2] : lo_word[DW/2-1:0];
  assign hi_half = hi.half ? hi_word[DW-1:DW/2] : hi_word[DW/2-1:0];

  // lo line is always refilled first
  assign miss_tag = lo_hit ? hi.tag : lo.tag;
  assign miss_idx = lo_hit ? hi.idx : lo.idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      vld          <= '0;
      req_hpc      <= '0;
      ref_tag      <= '0;
      ref_idx      <= '0;
      cnt          <= '0;
      killed       <= 1'b0;
      bus.if_en_o  <= 1'b0;
      bus.if_ins_o <= '0;
      bus.mc_en_o  <= 1'b0;
      bus.mc_adr_o <= '0;
    end else if (en) begin
      bus.if_en_o <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.if_en_i && !bus.br_flag_i) begin
            req_hpc <= bus.if_pc_i[AW-1:1];
            st      <= CHECK;
          end
        end
        CHECK: begin
          if (bus.br_flag_i) begin
            st <= IDLE;
          end else if (lo_hit && hi_hit) begin
            bus.if_en_o  <= 1'b1;
            bus.if_ins_o <= {hi_half, lo_half};
            st           <= IDLE;
          end else begin
            ref_tag       <= miss_tag;
            ref_idx       <= miss_idx;
            vld[miss_idx] <= 1'b0;
            cnt           <= '0;
            killed        <= 1'b0;
            bus.mc_en_o   <= 1'b1;
            bus.mc_adr_o  <= {miss_tag, miss_idx, {WC_W{1'b0}}, 2'b00};
            st            <= REFILL;
          end
        end
        REFILL: begin
          if (bus.br_flag_i) killed <= 1'b1;
          if (bus.mc_en_o && bus.mc_en_i) begin
            bus.mc_en_o <= 1'b0;
            if (&cnt) begin
              vld[ref_idx]     <= 1'b1;
              tag_mem[ref_idx] <= ref_tag;
              st               <= (killed || bus.br_flag_i) ? IDLE : CHECK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (!bus.mc_en_o) begin
            bus.mc_en_o  <= 1'b1;
            bus.mc_adr_o <= {ref_tag, ref_idx, cnt, 2'b00};
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // data array has no reset; valid bits guard it
  always_ff @(posedge clk) begin
    if (!rst && en && st == REFILL && bus.mc_en_o && bus.mc_en_i)
      dat_mem[ref_idx][cnt] <= bus.mc_dat_i;
  end
endmodule
